// File: rtl/cpu32_pkg.sv
// cpu32_pkg: opcodes, ALU functions, instruction field positions and the shared ALU helper.
package cpu32_pkg;
  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_LUI  = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_B    = 4'h6;
  localparam logic [3:0] OP_JR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] FN_AND  = 4'h1;
  localparam logic [3:0] FN_OR   = 4'h2;
  localparam logic [3:0] FN_XOR  = 4'h3;
  localparam logic [3:0] FN_ADD  = 4'h4;
  localparam logic [3:0] FN_SUB  = 4'h5;
  localparam logic [3:0] FN_SHL  = 4'h6;
  localparam logic [3:0] FN_SHR  = 4'h7;
  localparam logic [3:0] FN_SLT  = 4'h8;
  localparam logic [3:0] FN_SLTU = 4'h9;
  localparam int OP_LSB = 28;
  localparam int FN_LSB = 24;
  localparam int RA_LSB = 20;
  localparam int RB_LSB = 16;
  localparam int RC_LSB = 12;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [3:0] LR = 4'd14;
  // a is the rB value, b is rC or simm; unlisted functions pass b through
  function automatic logic [31:0] alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      FN_AND:  alu = a & b;
      FN_OR:   alu = a | b;
      FN_XOR:  alu = a ^ b;
      FN_ADD:  alu = a + b;
      FN_SUB:  alu = a - b;
      FN_SHL:  alu = a << b[4:0];
      FN_SHR:  alu = a >> b[4:0];
      FN_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      FN_SLTU: alu = {31'b0, a < b};
      default: alu = b;
    endcase
  endfunction
endpackage

// File: rtl/cpu32_regfile.sv
// cpu32_regfile: 16x32 register file, two combinational reads, X and W write ports (X wins).
module cpu32_regfile
  import cpu32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we_x,
  input  logic [3:0]  wa_x,
  input  logic [31:0] wd_x,
  input  logic        we_w,
  input  logic [3:0]  wa_w,
  input  logic [31:0] wd_w
);
  logic [15:0][31:0] regs_q, regs_d;
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  always_comb begin
    regs_d = regs_q;
    if (we_w) regs_d[wa_w] = wd_w;
    if (we_x) regs_d[wa_x] = wd_x;
    if (!reset) regs_d = '0;
  end
  always_ff @(posedge clk) regs_q <= regs_d;
endmodule

// File: rtl/cpu32_core.sv
// cpu32_core: two-stage (X execute, W load writeback) 32-bit load/store core.
module cpu32_core
  import cpu32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] d_addr,
  output logic [31:0] d_data_w,
  output logic        d_data_we,
  input  logic [31:0] d_data_r
);
  logic [31:0] xpc_q, xpc_d;
  logic        halt_q, halt_d, w_vld_q, w_vld_d;
  logic [3:0]  w_reg_q, w_reg_d;
  logic [31:0] ir, simm, rb_v, rp_v, pc4, target, x_wd;
  logic [3:0]  op, fn, ra, rb, rc, rp, x_wa;
  logic        rd_a, rd_b, rd_c, stall, run, taken, link, x_we;
  assign ir   = halt_q ? NOP : i_data;
  assign op   = ir[OP_LSB +: 4];
  assign fn   = ir[FN_LSB +: 4];
  assign ra   = ir[RA_LSB +: 4];
  assign rb   = ir[RB_LSB +: 4];
  assign rc   = ir[RC_LSB +: 4];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign rp   = op == OP_ALU ? rc : ra;
  cpu32_regfile u_rf (
    .clk  (clk),
    .reset(reset),
    .ra1  (rb),
    .ra2  (rp),
    .rd1  (rb_v),
    .rd2  (rp_v),
    .we_x (x_we),
    .wa_x (x_wa),
    .wd_x (x_wd),
    .we_w (w_vld_q),
    .wa_w (w_reg_q),
    .wd_w (d_data_r)
  );
  always_comb begin
    rd_a = op inside {OP_SW, OP_BZ};
    rd_b = op inside {OP_ALU, OP_ALUI, OP_LW, OP_SW, OP_JR};
    rd_c = op == OP_ALU;
    // a load in W has not yet written its target, so any reader of it waits one cycle
    stall = w_vld_q & ((rd_a & ra == w_reg_q) | (rd_b & rb == w_reg_q) | (rd_c & rc == w_reg_q));
    run = reset & ~halt_q & ~stall;
    pc4 = xpc_q + 32'd4;
    target = op == OP_JR ? rb_v : pc4 + (simm << 2);
    taken = run & (op inside {OP_B, OP_JR} | (op == OP_BZ & ((rp_v == '0) ^ fn[0])));
    link = op inside {OP_B, OP_JR};
    i_addr = !reset ? '0 : (halt_q | stall | (run & op == OP_HALT)) ? xpc_q : taken ? target : pc4;
    x_we = run & (op inside {OP_ALU, OP_ALUI, OP_LUI} | (link & fn[0]));
    x_wa = link ? LR : ra;
    x_wd = op == OP_LUI ? {ir[15:0], 16'h0} : link ? pc4 : alu(fn, rb_v, op == OP_ALU ? rp_v : simm);
    d_addr = reset ? rb_v + simm : '0;
    d_data_w = reset ? rp_v : '0;
    d_data_we = run & op == OP_SW;
    w_vld_d = run & op == OP_LW;
    w_reg_d = ra;
    halt_d = reset & (halt_q | (run & op == OP_HALT));
    xpc_d = i_addr;
  end
  always_ff @(posedge clk) begin
    xpc_q <= xpc_d;
    halt_q <= halt_d;
    w_vld_q <= w_vld_d;
    w_reg_q <= w_reg_d;
  end
endmodule

// File: tb/tb_cpu32_core.sv
// tb_cpu32_core: runs a small program against a behavioural sync memory, scoreboarding fetches and stores.
module tb_cpu32_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] i_addr, i_data, d_addr, d_data_w, d_data_r;
  logic d_data_we;
  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t sq[$];
  logic [31:0] fq[$];
  cpu32_core dut (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .d_addr   (d_addr),
    .d_data_w (d_data_w),
    .d_data_we(d_data_we),
    .d_data_r (d_data_r)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    i_data <= mem[i_addr[13:2]];
    d_data_r <= mem[d_addr[13:2]];
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic run_trace(input int n);
    st_t s;
    logic [31:0] e;
    logic exp_we;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp_we = sq.size() > 0 && sq[0].cyc == c;
      check($sformatf("d_data_we@%0d", c), {31'b0, d_data_we}, {31'b0, exp_we});
      if (exp_we) begin
        s = sq.pop_front();
        check($sformatf("d_addr@%0d", c), d_addr, s.addr);
        check($sformatf("d_data_w@%0d", c), d_data_w, s.data);
      end
      if (c == 3) check("lw_addr", d_addr, 32'h100);
      e = fq.pop_front();
      check($sformatf("i_addr@%0d", c), i_addr, e);
    end
  endtask
  initial begin
    logic [31:0] prog [13];
    logic [31:0] trace [16];
    prog = '{32'h14100005, 32'h2020E000, 32'h40120000, 32'h30300100, 32'h04433000,
             32'h40420000, 32'h14600005, 32'h03776000, 32'h5170FFFE, 32'h61000002,
             32'h40E20000, 32'hFFFFFFFF, 32'h700E0000};
    trace = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h20, 32'h1C, 32'h20, 32'h24, 32'h30, 32'h28, 32'h2C, 32'h2C};
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < 13; i++) mem[i] = prog[i];
    mem[32'h100 >> 2] = 32'd7;
    for (int i = 0; i < 16; i++) fq.push_back(trace[i]);
    for (int i = 0; i < 10; i++) fq.push_back(32'h2C);
    sq.push_back('{2, 32'hE000_0000, 32'd5});
    sq.push_back('{6, 32'hE000_0000, 32'd14});
    sq.push_back('{14, 32'hE000_0000, 32'h28});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_addr", i_addr, 32'h0);
    check("rst_we", {31'b0, d_data_we}, 32'h0);
    check("rst_d_addr", d_addr, 32'h0);
    check("rst_d_data_w", d_data_w, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_trace(26);
    check("stores_left", sq.size(), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("halt_rst_i_addr", i_addr, 32'h0);
    check("halt_rst_we", {31'b0, d_data_we}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("restart_i_addr0", i_addr, 32'h4);
    @(negedge clk);
    check("restart_i_addr1", i_addr, 32'h8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
